// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Central stall scheduler merging ID load-use, EX divider and
//               MEM SRAM-wait requests into one per-stage stall bus.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int STALL_W    = 6,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_id,
    input  logic               ex_div_req,
    input  logic               stallreq_mem,
    output logic [STALL_W-1:0] stall,
    output logic               div_busy,
    output logic               div_done,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int c_CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_LOAD = c_CW'(DIV_CYCLES - 2);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [STALL_W-1:0] c_STALL_MEM  = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] c_STALL_DIV  = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] c_STALL_ID   = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] c_STALL_NONE = '0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CW-1:0]    r_cnt;
    logic [c_CW-1:0]    w_cnt_nxt;
    logic [STALL_W-1:0] w_stall;
    logic               w_div_stall;
    logic [CNT_W-1:0]   r_stall_cnt;

    // The issue cycle stalls too, so RUN only has to cover DIV_CYCLES-2 cycles;
    // with DIV_CYCLES==2 there is no RUN phase at all.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (ex_div_req) begin
                    w_cnt_nxt   = c_LOAD;
                    w_state_nxt = (DIV_CYCLES > 2) ? c_RUN : c_DONE;
                end
            end
            c_RUN: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt <= c_ONE) begin
                    w_state_nxt = c_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            c_DONE: begin
                if (!stallreq_mem) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_div_stall = (r_state == c_RUN) || ((r_state == c_IDLE) && ex_div_req);

    always_comb begin
        w_stall = c_STALL_NONE;
        if (stallreq_mem) begin
            w_stall = c_STALL_MEM;
        end else if (w_div_stall) begin
            w_stall = c_STALL_DIV;
        end else if (stallreq_id) begin
            w_stall = c_STALL_ID;
        end
    end

    // Requests may be live during reset; the bus must still read all-go.
    assign stall = resetn ? w_stall : c_STALL_NONE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign div_busy  = (r_state == c_RUN);
    assign div_done  = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed + random bench for pipeline_stall_ctrl against a
//               cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam int DIVC = 33;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            stallreq_id = 1'b0;
    logic            ex_div_req = 1'b0;
    logic            stallreq_mem = 1'b0;
    logic [5:0]      stall;
    logic            div_busy;
    logic            div_done;
    logic [CNTW-1:0] stall_cnt;

    pipeline_stall_ctrl #(
        .STALL_W   (6),
        .DIV_CYCLES(DIVC),
        .CNT_W     (CNTW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stallreq_id (stallreq_id),
        .ex_div_req  (ex_div_req),
        .stallreq_mem(stallreq_mem),
        .stall       (stall),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: remaining divider stall cycles after the issue, result-pending flag.
    int m_left = 0;
    bit m_done = 1'b0;
    int m_cnt  = 0;

    logic [5:0] last_stall;
    logic       last_done;

    function automatic logic [5:0] exp_stall();
        if (!resetn)                               return 6'b000000;
        if (stallreq_mem)                          return 6'b011111;
        if (m_left > 0 || (!m_done && ex_div_req)) return 6'b001111;
        if (stallreq_id)                           return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [5:0] s;
        s = exp_stall();
        if (s[0] && m_cnt < CMAX) m_cnt++;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            if (!stallreq_mem) m_done = 1'b0;
        end else if (ex_div_req) begin
            m_left = DIVC - 2;
            if (m_left == 0) m_done = 1'b1;
        end
    endtask

    task automatic cycle(input logic id, input logic dv, input logic mm, input string tag);
        stallreq_id  = id;
        ex_div_req   = dv;
        stallreq_mem = mm;
        #2;
        last_stall = stall;
        last_done  = div_done;
        chk({tag, "_stall"}, 32'(stall), 32'(exp_stall()));
        chk({tag, "_busy"}, 32'(div_busy), 32'(m_left > 0));
        chk({tag, "_done"}, 32'(div_done), 32'(m_done));
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Asserts reset mid-cycle with whatever requests are currently driven.
    task automatic do_reset(input string tag);
        resetn = 1'b0;
        #1;
        chk({tag, "_rst_stall"}, 32'(stall), 32'h0);
        chk({tag, "_rst_busy"}, 32'(div_busy), 32'h0);
        chk({tag, "_rst_done"}, 32'(div_done), 32'h0);
        chk({tag, "_rst_cnt"}, 32'(stall_cnt), 32'h0);
        m_left = 0;
        m_done = 1'b0;
        m_cnt  = 0;
        @(posedge clk);
        #1;
        stallreq_id  = 1'b0;
        ex_div_req   = 1'b0;
        stallreq_mem = 1'b0;
        resetn = 1'b1;
    endtask

    initial begin
        logic [CNTW-1:0] pre;
        logic dv;

        do_reset("init");

        // Single load-use cycle
        pre = stall_cnt;
        cycle(1'b1, 1'b0, 1'b0, "id1");
        chk("id1_pattern", 32'(last_stall), 32'h07);
        chk("id1_cnt_inc", 32'(stall_cnt), 32'(pre) + 1);
        cycle(1'b0, 1'b0, 1'b0, "id1_after");
        chk("id1_after_pattern", 32'(last_stall), 32'h00);

        // Isolated divide, request held from issue
        for (int k = 0; k <= DIVC - 1; k++) begin
            cycle(1'b0, 1'b1, 1'b0, "div");
            if (k < DIVC - 1) chk("div_stall_fixed", 32'(last_stall), 32'h0F);
            else              chk("div_done_fixed", 32'(last_done), 32'h1);
        end
        cycle(1'b0, 1'b0, 1'b0, "div_gap");
        chk("div_gap_done", 32'(last_done), 32'h0);

        // Result held while MEM waits
        for (int k = 0; k < DIVC - 1; k++) cycle(1'b0, 1'b1, 1'b0, "dm_run");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b1, "dm_hold");
            chk("dm_hold_stall", 32'(last_stall), 32'h1F);
            chk("dm_hold_done", 32'(last_done), 32'h1);
        end
        cycle(1'b0, 1'b1, 1'b0, "dm_retire");
        cycle(1'b0, 1'b0, 1'b0, "dm_idle");
        chk("dm_idle_done", 32'(last_done), 32'h0);

        // MEM pulse and load-use during RUN do not freeze the countdown
        for (int k = 0; k <= DIVC - 1; k++) begin
            cycle((k >= 3 && k <= 10), 1'b1, (k == 5 || k == 6), "mix");
            if (k == 5 || k == 6)  chk("mix_mem_stall", 32'(last_stall), 32'h1F);
            else if (k < DIVC - 1) chk("mix_div_stall", 32'(last_stall), 32'h0F);
            else                   chk("mix_done", 32'(last_done), 32'h1);
        end
        cycle(1'b0, 1'b0, 1'b0, "mix_idle");

        // Reset while the divider is counting
        for (int k = 0; k < 22; k++) cycle(1'b0, 1'b1, 1'b0, "rr_run");
        ex_div_req = 1'b1;
        #2;
        do_reset("rr");
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 1'b0, 1'b0, "rr_post");
            chk("rr_post_nodone", 32'(last_done), 32'h0);
        end

        // Random traffic, including rare mid-RUN request drops
        for (int k = 0; k < 600; k++) begin
            if (m_left > 0 || m_done) dv = ($urandom_range(0, 19) != 0);
            else                      dv = ($urandom_range(0, 5) == 0);
            cycle(($urandom_range(0, 9) < 2), dv, ($urandom_range(0, 9) == 0), "rnd");
        end

        // Perf counter saturation
        do_reset("sat");
        for (int k = 0; k < CMAX + 1 + 5; k++) begin
            cycle(1'b0, 1'b0, 1'b1, "sat");
            if (k == 13) chk("sat_mid", 32'(stall_cnt), 32'd14);
        end
        chk("sat_final", 32'(stall_cnt), 32'(CMAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
